// File: rtl/ram_burst_reader.sv
// Burst read controller for the 128x8 dual-port RAM (async read port B).
// Ports: ck/rst, start+start_adr+len, adr_b/mem_data to RAM, out_* stream, busy, done.
module ram_burst_reader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adr,
  input  logic [7:0]        len,
  output logic [ADDR_W-1:0] adr_b,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   adr_n;
  logic [DATA_W-1:0]   data_n;
  logic                valid_n;
  logic                busy_n;
  logic                done_n;
  logic [7:0]          fetch_q, fetch_n;
  logic [7:0]          remain_q, remain_n;
  logic [7:0]          len_l;
  logic                load;
  logic                hs;

  // A burst never needs to cover more than the whole RAM once.
  always_comb begin
    len_l = len;
    if ({1'b0, len} > DEPTH_W)
      len_l = DEPTH_W[7:0];
  end

  always_comb begin
    state_n  = state_q;
    adr_n    = adr_b;
    data_n   = out_data;
    valid_n  = out_valid;
    busy_n   = busy;
    done_n   = 1'b0;
    fetch_n  = fetch_q;
    remain_n = remain_q;
    load     = 1'b0;
    hs       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && len != 8'd0) begin
          adr_n    = start_adr;
          fetch_n  = len_l;
          remain_n = len_l;
          busy_n   = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        hs   = out_valid && out_ready;
        // Refill the output register when it is empty or drains this edge.
        load = (fetch_q != 8'd0) && (!out_valid || out_ready);
        if (hs) begin
          remain_n = remain_q - 8'd1;
          valid_n  = 1'b0;
        end
        if (load) begin
          data_n  = mem_data;
          valid_n = 1'b1;
          adr_n   = adr_b + ADDR_W'(1);
          fetch_n = fetch_q - 8'd1;
        end
        if (hs && remain_q == 8'd1) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      adr_b     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fetch_q   <= 8'd0;
      remain_q  <= 8'd0;
    end else begin
      state_q   <= state_n;
      adr_b     <= adr_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      fetch_q   <= fetch_n;
      remain_q  <= remain_n;
    end
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side controller for the 128x8 dual-port RAM (synchronous write port A, asynchronous read port B).
- Given a start address and a length, walks the read address through the RAM and streams the bytes out over a valid/ready handshake.
- Throughput is one byte per clock while the sink is ready.
- Sits between the RAM read port and any byte consumer (UART TX, display driver, DMA-style sink).

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 8, RAM word width.
- DEPTH, 128, number of RAM words; equals 2**ADDR_W; address wraps modulo DEPTH.

Ports:
- ck  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a burst; sampled on posedge, only in IDLE.
- start_adr  input  ADDR_W  first RAM address of the burst.
- len  input  8  burst length in words.
- adr_b  output  ADDR_W  RAM read address (port B); driven from an internal register.
- mem_data  input  DATA_W  RAM asynchronous read data for adr_b.
- out_data  output  DATA_W  streamed byte (registered).
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  sink accepts out_data this cycle.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: on any posedge with rst=1, the following values apply. rst has priority over every other input, including mid-burst.
  - state=IDLE, adr_b=0, out_data=0, out_valid=0, busy=0, done=0.
  - Internal fetch counter = 0, remaining counter = 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 and len!=0: adr_b<=start_adr, fetch_left<=L, remain<=L, busy<=1, state<=RUN.
  - L = len, clamped to DEPTH when len > DEPTH.
  - start=1 and len=0: ignored; no busy, no done.
- RUN, load condition: fetch_left!=0 and (out_valid=0 or out_ready=1).
  - out_data<=mem_data, out_valid<=1, adr_b<=(adr_b+1) mod DEPTH, fetch_left<=fetch_left-1.
- RUN, handshake: out_valid=1 and out_ready=1 consumes a byte and decrements remain.
  - If no new byte loads the same edge, out_valid<=0.
- RUN, stall: while out_valid=1 and out_ready=0, out_data, out_valid and adr_b hold stable.
- Burst end: the handshake with remain=1 is the last one.
  - That edge: out_valid<=0, busy<=0, state<=IDLE.
  - done=1 for exactly the following cycle.
- Latency: start sampled at edge T gives the first byte on out_data with out_valid=1 after edge T+1.
  - With out_ready held high, byte k appears after edge T+1+k.
  - done is high in the cycle after edge T+L+1.
- Wrap-around: the address increments modulo DEPTH.
  - start_adr=126, len=4 reads addresses 126, 127, 0, 1.
- start while busy is ignored; start_adr and len are sampled only at the accepting edge.
- A back-to-back start may be accepted in the cycle done is high (state is IDLE).
- The block never writes the RAM. Data written through port A to a not-yet-fetched address during a burst is returned with its new value. Data at an already-fetched address is not re-read.
- out_valid never drops without a handshake, except on rst.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 -> adr_b=0, out_valid=0, busy=0, done=0 throughout.
- Basic burst: preload mem[i]=i+8'h10, start_adr=5, len=3, out_ready=1.
  - Expect out_data 8'h15, 8'h16, 8'h17 on consecutive cycles starting the 2nd edge after start.
  - busy high for 4 cycles; done pulses once.
- Backpressure: same burst, out_ready=0 for 3 cycles after the first valid.
  - Expect out_data=8'h15 held stable, adr_b held.
  - Stream resumes without loss or duplication; total 3 handshakes.
- Wrap and clamp:
  - start_adr=126, len=4 -> addresses 126, 127, 0, 1 in order.
  - len=200 -> exactly 128 bytes, then done.
- Illegal/ignored starts:
  - len=0 -> busy stays 0, no done.
  - start pulsed mid-burst with a different start_adr -> current burst unaffected.
- Reset mid-burst: rst=1 after the 2nd handshake of a len=10 burst.
  - Next edge: out_valid=0, busy=0, no done.
  - A new start afterwards runs normally.
